modular_op_scheduler: RTL and testbench

Sequencer and two-port arbiter for the shared modular adder/subtractor datapath. Two requesters submit operand pairs with an add/subtract select. The block grants one requester at a time in round-robin order and holds the operands stable on the combinational datapath for a programmable settle time. It then captures the 4-bit result and returns it, tagged with the requester id, over a valid/ready result port. It sits between the client logic and the three-stage modular datapath, which is instantiated alongside it at the top level.

---
 rtl/modular_op_scheduler_pkg.sv | 9 +
 rtl/modular_op_scheduler_if.sv | 18 +
 rtl/modular_op_scheduler_rr_arbiter2.sv | 17 +
 rtl/modular_op_scheduler.sv | 67 ++++++
 tb/tb_modular_op_scheduler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/modular_op_scheduler_pkg.sv
// modular_pkg: shared width, op/id encodings and scheduler states for the modular datapath
package modular_pkg;
    localparam int WIDTH = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;
    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, HOLD} state_e;
endpackage

// File: rtl/modular_op_scheduler_if.sv
// modular_op_scheduler_if: request, datapath and result signals between clients and the scheduler
interface modular_op_scheduler_if #(parameter int WIDTH = modular_pkg::WIDTH);
    logic a_valid, b_valid, a_ready, b_ready;
    logic [WIDTH-1:0] a_x, a_y, b_x, b_y;
    logic a_s, b_s;
    logic [WIDTH-1:0] dp_x, dp_y, dp_z;
    logic dp_s;
    logic res_valid, res_ready, res_id, busy;
    logic [WIDTH-1:0] res_z;
    modport master (
        output a_valid, b_valid, a_x, a_y, b_x, b_y, a_s, b_s, dp_z, res_ready,
        input  a_ready, b_ready, dp_x, dp_y, dp_s, res_valid, res_z, res_id, busy
    );
    modport slave (
        input  a_valid, b_valid, a_x, a_y, b_x, b_y, a_s, b_s, dp_z, res_ready,
        output a_ready, b_ready, dp_x, dp_y, dp_s, res_valid, res_z, res_id, busy
    );
endinterface

// File: rtl/modular_op_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-port round-robin grant; ptr holds the id granted last
module rr_arbiter2
    import modular_pkg::*;
(
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       en,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       grant_id
);
    always_comb begin
        grant[0] = en & a_valid & (~b_valid | (ptr == ID_B));
        grant[1] = en & b_valid & (~a_valid | (ptr == ID_A));
        grant_id = grant[1] ? ID_B : ID_A;
    end
endmodule

// File: rtl/modular_op_scheduler.sv
// modular_op_scheduler: arbitrates two requesters onto the modular datapath and returns tagged results
module modular_op_scheduler #(
    parameter int WIDTH  = modular_pkg::WIDTH,
    parameter int SETTLE = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    modular_op_scheduler_if.slave   bus
);
    import modular_pkg::*;
    state_e           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] op_x, op_y, res_z;
    logic             op_s, op_id, ptr;
    logic [1:0]       grant;
    logic             grant_id;
    // readies stay low while reset is held, not just after the first clock
    rr_arbiter2 u_arb (
        .a_valid  (bus.a_valid),
        .b_valid  (bus.b_valid),
        .en       (rst_n && state == IDLE),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );
    assign bus.a_ready   = grant[0];
    assign bus.b_ready   = grant[1];
    assign bus.dp_x      = op_x;
    assign bus.dp_y      = op_y;
    assign bus.dp_s      = op_s;
    assign bus.res_valid = state == HOLD;
    assign bus.res_z     = res_z;
    assign bus.res_id    = op_id;
    assign bus.busy      = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_x  <= '0;
            op_y  <= '0;
            op_s  <= OP_ADD;
            op_id <= ID_A;
            ptr   <= ID_B;
            res_z <= '0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    op_x  <= grant_id ? bus.b_x : bus.a_x;
                    op_y  <= grant_id ? bus.b_y : bus.a_y;
                    op_s  <= grant_id ? bus.b_s : bus.a_s;
                    op_id <= grant_id;
                    ptr   <= grant_id;
                    cnt   <= 4'(SETTLE - 1);
                    state <= SETTLE_WAIT;
                end
                SETTLE_WAIT: if (cnt == 4'd0) begin
                    res_z <= bus.dp_z;
                    state <= HOLD;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: if (bus.res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modular_op_scheduler.sv
// tb_modular_op_scheduler: directed and randomized checks of the scheduler against a latency-level model
module tb_modular_op_scheduler;
    import modular_pkg::*;
    localparam int S = 2;
    logic clk = 0, rst_n = 0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    modular_op_scheduler_if #(.WIDTH(4)) bus ();
    modular_op_scheduler_if #(.WIDTH(4)) bus1 ();
    modular_op_scheduler_if #(.WIDTH(4)) bus15 ();
    modular_op_scheduler #(.WIDTH(4), .SETTLE(S))  dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    modular_op_scheduler #(.WIDTH(4), .SETTLE(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    modular_op_scheduler #(.WIDTH(4), .SETTLE(15)) u15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    function automatic logic [3:0] modf(input logic [3:0] x, input logic [3:0] y, input logic s);
        int r;
        r = s ? int'(x) - int'(y) : int'(x) + int'(y);
        return 4'(((r % 13) + 13) % 13);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    always @(posedge clk) bus.dp_z <= modf(bus.dp_x, bus.dp_y, bus.dp_s);
    assign bus1.dp_z  = modf(bus1.dp_x, bus1.dp_y, bus1.dp_s);
    assign bus15.dp_z = modf(bus15.dp_x, bus15.dp_y, bus15.dp_s);

    // model: age = cycles since accept (-1 when idle), last = id granted last
    int age = -1;
    logic last = ID_B;
    logic [3:0] ex = 0, ey = 0, ez = 0;
    logic es = 0, eid = 0, ra, rb;
    always @(negedge clk) begin
        if (!rst_n) begin
            age = -1; last = ID_B; ex = 0; ey = 0; ez = 0; es = 0; eid = 0;
            chk("rst_ready", {bus.a_ready, bus.b_ready}, 0);
            chk("rst_out", {bus.res_valid, bus.busy, bus.res_id, bus.res_z, bus.dp_x, bus.dp_y, bus.dp_s}, 0);
        end else begin
            ra = bus.a_valid && age < 0 && (!bus.b_valid || last == ID_B);
            rb = bus.b_valid && age < 0 && (!bus.a_valid || last == ID_A);
            chk("a_ready", bus.a_ready, ra);
            chk("b_ready", bus.b_ready, rb);
            chk("busy", bus.busy, age > 0);
            chk("res_valid", bus.res_valid, age > S);
            chk("dp", {bus.dp_x, bus.dp_y, bus.dp_s}, {ex, ey, es});
            if (age > S) chk("res", {bus.res_id, bus.res_z}, {eid, ez});
            if (ra || rb) begin
                ex = rb ? bus.b_x : bus.a_x;
                ey = rb ? bus.b_y : bus.a_y;
                es = rb ? bus.b_s : bus.a_s;
                eid = rb; last = rb; ez = modf(ex, ey, es); age = 1;
            end else if (age > S && bus.res_ready) age = -1;
            else if (age > 0) age++;
        end
    end

    logic hs_a, hs_b, rv, rid;
    logic [3:0] rz;
    task automatic tick();
        @(negedge clk);
        hs_a = bus.a_valid & bus.a_ready;
        hs_b = bus.b_valid & bus.b_ready;
        rv = bus.res_valid; rz = bus.res_z; rid = bus.res_id;
        @(posedge clk); #1;
        if (hs_a) bus.a_valid = 0;
        if (hs_b) bus.b_valid = 0;
    endtask

    task automatic wait_res(output int n);
        n = -1;
        do begin tick(); n++; end while (!rv && n < 60);
        chk("res_timeout", rv, 1);
    endtask

    task automatic req_a(input logic [3:0] x, input logic [3:0] y, input logic s);
        bus.a_x = x; bus.a_y = y; bus.a_s = s; bus.a_valid = 1;
    endtask

    task automatic req_b(input logic [3:0] x, input logic [3:0] y, input logic s);
        bus.b_x = x; bus.b_y = y; bus.b_s = s; bus.b_valid = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int n, n1, n15;
        logic g [$];
        logic [3:0] hz;
        logic hid;
        bus.a_valid = 0; bus.b_valid = 0; bus.res_ready = 0;
        bus.a_x = 0; bus.a_y = 0; bus.a_s = 0; bus.b_x = 0; bus.b_y = 0; bus.b_s = 0;
        bus1.a_valid = 0; bus1.b_valid = 0; bus1.res_ready = 1;
        bus1.a_x = 9; bus1.a_y = 7; bus1.a_s = OP_ADD; bus1.b_x = 0; bus1.b_y = 0; bus1.b_s = 0;
        bus15.a_valid = 0; bus15.b_valid = 0; bus15.res_ready = 1;
        bus15.a_x = 9; bus15.a_y = 7; bus15.a_s = OP_ADD; bus15.b_x = 0; bus15.b_y = 0; bus15.b_s = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_res_valid", bus.res_valid, 0);
        rst_n = 1;
        // single A: 9+7 mod 13 = 3
        req_a(9, 7, OP_ADD); bus.res_ready = 1;
        wait_res(n);
        chk("single_lat", n, 3); chk("single_z", rz, 3); chk("single_id", rid, ID_A);
        // tie straight out of reset: A (5-8 = 10) then B (2+2 = 4)
        rst_n = 0; @(negedge clk); @(posedge clk); #1; rst_n = 1;
        req_a(5, 8, OP_SUB); req_b(2, 2, OP_ADD);
        wait_res(n);
        chk("tie_a_z", rz, 10); chk("tie_a_id", rid, ID_A);
        wait_res(n);
        chk("tie_b_lat", n, 3); chk("tie_b_z", rz, 4); chk("tie_b_id", rid, ID_B);
        // both valid continuously: grants must alternate
        req_a(1, 2, OP_ADD); req_b(3, 4, OP_SUB);
        for (int c = 0; c < 60 && g.size() < 4; c++) begin
            tick();
            if (hs_a) begin g.push_back(ID_A); req_a(4'(c), 5, OP_ADD); end
            if (hs_b) begin g.push_back(ID_B); req_b(4'(c), 6, OP_SUB); end
        end
        chk("alt_count", g.size(), 4);
        for (int i = 0; i < g.size(); i++) chk("alt_order", g[i], i % 2);
        // stall in HOLD with both requests pending
        bus.res_ready = 0;
        wait_res(n);
        hz = rz; hid = rid;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", rv, 1); chk("stall_z", rz, hz); chk("stall_id", rid, hid);
            chk("stall_accept", hs_a | hs_b, 0);
        end
        bus.res_ready = 1;
        tick();
        chk("release_no_accept", hs_a | hs_b, 0);
        tick();
        chk("release_accept", hs_a | hs_b, 1);
        bus.a_valid = 0; bus.b_valid = 0;
        wait_res(n);
        // reset in the middle of SETTLE_WAIT
        req_a(3, 3, OP_ADD);
        tick(); tick();
        #1; rst_n = 0; #1;
        chk("async_busy", bus.busy, 0); chk("async_valid", bus.res_valid, 0);
        chk("async_dp", {bus.dp_x, bus.dp_y, bus.dp_s, bus.res_z}, 0);
        @(posedge clk); #1; rst_n = 1;
        for (int i = 0; i < S + 3; i++) begin tick(); chk("post_rst_no_res", rv, 0); end
        req_a(7, 1, OP_SUB); req_b(8, 8, OP_ADD);
        tick();
        chk("post_rst_tie", {hs_a, hs_b}, 2'b10);
        bus.b_valid = 0;
        wait_res(n);
        chk("post_rst_z", rz, 6);
        // randomized traffic checked by the model
        for (int c = 0; c < 600; c++) begin
            if (!bus.a_valid && $urandom_range(3) == 0) req_a(4'($urandom), 4'($urandom), 1'($urandom));
            else if (bus.a_valid && $urandom_range(15) == 0) bus.a_valid = 0;
            if (!bus.b_valid && $urandom_range(3) == 0) req_b(4'($urandom), 4'($urandom), 1'($urandom));
            else if (bus.b_valid && $urandom_range(15) == 0) bus.b_valid = 0;
            bus.res_ready = $urandom_range(2) != 0;
            tick();
        end
        bus.a_valid = 0; bus.b_valid = 0; bus.res_ready = 1;
        repeat (S + 3) tick();
        // latency of the SETTLE=1 and SETTLE=15 builds
        bus1.a_valid = 1; bus15.a_valid = 1; n1 = -1; n15 = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) chk("lat_ready", {bus1.a_ready, bus15.a_ready}, 2'b11);
            if (n1 < 0 && bus1.res_valid) begin n1 = c; chk("s1_z", bus1.res_z, 3); end
            if (n15 < 0 && bus15.res_valid) begin n15 = c; chk("s15_z", bus15.res_z, 3); end
            @(posedge clk); #1;
            bus1.a_valid = 0; bus15.a_valid = 0;
        end
        chk("s1_lat", n1, 2);
        chk("s15_lat", n15, 16);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
